noise_ctrl: RTL and testbench

NOISE_CTRL -- requirements
Module: noise_ctrl

---
 rtl/noise_ctrl.sv | 120 ++++++++++++
 tb/tb_noise_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/noise_ctrl.sv
// Noise-channel control: register decode plus LFSR shift/reload pulse generation.
// Define NOISE_ATTEN_EN to implement the address-111 attenuation register.
module noise_ctrl #(
   parameter int BASE_DIV = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   input  logic       wr,
   input  logic [7:0] din,
   input  logic       tone3,
   output logic       noise_clk,
   output logic       mode,
   output logic       lfsr_rst,
   output logic [3:0] atten
);

   logic [2:0] latch_q, latch_d;
   logic       fb_q, fb_d;
   logic [1:0] rate_q, rate_d;
   logic [7:0] cnt_q, cnt_d;
   logic       tone3_q;
   logic       noise_clk_q, noise_clk_d;
   logic       lfsr_rst_q, lfsr_rst_d;

   logic [2:0] addr_s;
   logic       wr_noise_s;
   logic [9:0] term_s;
   logic       at_term_s;

   // A data byte reuses the last latched address; a latch byte carries its own.
   always_comb begin
      addr_s     = din[7] ? din[6:4] : latch_q;
      wr_noise_s = wr && (addr_s == 3'b110);
      term_s     = (10'(BASE_DIV) << rate_q) - 10'd1;
      at_term_s  = ({2'b00, cnt_q} == term_s);
   end

   always_comb begin
      latch_d     = latch_q;
      fb_d        = fb_q;
      rate_d      = rate_q;
      cnt_d       = cnt_q;
      noise_clk_d = 1'b0;
      lfsr_rst_d  = 1'b0;
      if (wr && din[7]) begin
         latch_d = din[6:4];
      end else begin
         latch_d = latch_q;
      end
      // A control write wins over terminal count or a tone3 edge in the same cycle.
      if (wr_noise_s) begin
         fb_d       = din[2];
         rate_d     = din[1:0];
         cnt_d      = 8'd0;
         lfsr_rst_d = 1'b1;
      end else if (rate_q == 2'b11) begin
         cnt_d       = 8'd0;
         noise_clk_d = tone3 & ~tone3_q;
      end else if (clk_en) begin
         if (at_term_s) begin
            cnt_d       = 8'd0;
            noise_clk_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         latch_q     <= 3'b000;
         fb_q        <= 1'b0;
         rate_q      <= 2'b00;
         cnt_q       <= 8'd0;
         tone3_q     <= 1'b0;
         noise_clk_q <= 1'b0;
         lfsr_rst_q  <= 1'b0;
      end else begin
         latch_q     <= latch_d;
         fb_q        <= fb_d;
         rate_q      <= rate_d;
         cnt_q       <= cnt_d;
         tone3_q     <= tone3;
         noise_clk_q <= noise_clk_d;
         lfsr_rst_q  <= lfsr_rst_d;
      end
   end

`ifdef NOISE_ATTEN_EN
   logic [3:0] atten_q;
   logic       wr_atten_s;

   assign wr_atten_s = wr && (addr_s == 3'b111);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         atten_q <= 4'hF;
      end else if (wr_atten_s) begin
         atten_q <= din[3:0];
      end else begin
         atten_q <= atten_q;
      end
   end

   assign atten = atten_q;
`else
   // Bit 3 of the data nibble only matters to the attenuation register.
   logic unused_s;
   assign unused_s = din[3];
   assign atten    = 4'hF;
`endif

   assign noise_clk = noise_clk_q;
   assign lfsr_rst  = lfsr_rst_q;
   assign mode      = fb_q;

endmodule

// File: tb/tb_noise_ctrl.sv
// Scoreboard bench for noise_ctrl: expected pulse cycles are queued when stimulus
// is driven and matched against observed noise_clk / lfsr_rst pulses.
module tb_noise_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clk_en = 1'b1;
   logic       wr = 1'b0;
   logic [7:0] din = 8'h00;
   logic       tone3 = 1'b0;
   logic       noise_clk, mode, lfsr_rst;
   logic [3:0] atten;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   int nq[$];
   int lq[$];
   bit en_alt = 1'b0;

`ifdef NOISE_ATTEN_EN
   localparam int ATT_A = 7;
   localparam int ATT_B = 3;
`else
   localparam int ATT_A = 15;
   localparam int ATT_B = 15;
`endif

   noise_ctrl #(.BASE_DIV(32)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .wr(wr), .din(din), .tone3(tone3),
      .noise_clk(noise_clk), .mode(mode), .lfsr_rst(lfsr_rst), .atten(atten)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Pulse monitor: every observed pulse must match the head of its queue.
   always @(negedge clk) begin
      if (noise_clk === 1'b1) begin
         if (nq.size() == 0) check_eq("noise_clk_extra", cyc, -1);
         else check_eq("noise_clk_cycle", cyc, nq.pop_front());
      end
      if (lfsr_rst === 1'b1) begin
         if (lq.size() == 0) check_eq("lfsr_rst_extra", cyc, -1);
         else check_eq("lfsr_rst_cycle", cyc, lq.pop_front());
      end
      if (noise_clk === 1'b1 && lfsr_rst === 1'b1) check_eq("pulse_overlap", 1, 0);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         wr = 1'b0;
         clk_en = en_alt ? (((cyc + 1) % 2) == 0) : 1'b1;
      end
   endtask

   task automatic run_to(input int t);
      while (cyc < t) step(1);
   endtask

   // Drives one write; returns the cycle number at which it was presented.
   task automatic wr_byte(input logic [7:0] b, input bit exp_lrst, output int k);
      @(negedge clk);
      wr = 1'b1;
      din = b;
      clk_en = en_alt ? (((cyc + 1) % 2) == 0) : 1'b1;
      k = cyc;
      if (exp_lrst) lq.push_back(k + 1);
      step(1);
   endtask

   task automatic drain(input string tag);
      check_eq({tag, "_noise_left"}, nq.size(), 0);
      check_eq({tag, "_lfsr_left"}, lq.size(), 0);
      nq.delete();
      lq.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_noise_clk"}, int'(noise_clk), 0);
      check_eq({tag, "_lfsr_rst"}, int'(lfsr_rst), 0);
      check_eq({tag, "_mode"}, int'(mode), 0);
      check_eq({tag, "_atten"}, int'(atten), 15);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, k2, r, w, f, p0;

      // Reset state, release, and writes that must be ignored.
      step(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      r = cyc;
      nq.push_back(r + 32);
      nq.push_back(r + 64);
      step(4);
      wr_byte(8'h05, 1'b0, k);
      wr_byte(8'h9A, 1'b0, k);
      wr_byte(8'h06, 1'b0, k);
      check_eq("ignored_mode", int'(mode), 0);
      run_to(r + 70);
      drain("after_reset");

      // 0xE5: white noise, rate 1 -> period 64.
      wr_byte(8'hE5, 1'b1, k);
      check_eq("e5_mode", int'(mode), 1);
      for (int i = 1; i <= 3; i++) nq.push_back(k + 1 + 64 * i);
      run_to(k + 201);
      drain("rate1");

      // 0xE3: rate 3, noise_clk follows tone3 rising edges only.
      wr_byte(8'hE3, 1'b1, k);
      check_eq("e3_mode", int'(mode), 0);
      step(2);
      for (int i = 0; i < 4; i++) begin
         step(1);
         tone3 = 1'b1;
         nq.push_back(cyc + 1);
         step(5);
         tone3 = 1'b0;
         step(4);
      end
      step(5);
      drain("tone3");

      // Attenuation register via latch byte then data byte.
      wr_byte(8'hF7, 1'b0, k);
      check_eq("atten_f7", int'(atten), ATT_A);
      wr_byte(8'h03, 1'b0, k);
      check_eq("atten_03", int'(atten), ATT_B);
      check_eq("atten_mode", int'(mode), 0);
      step(3);
      drain("atten");

      // 0xE0, 20 ticks later data byte 0x02 -> rate 2, counter restarted.
      wr_byte(8'hE0, 1'b1, k);
      run_to(k + 20);
      wr_byte(8'h02, 1'b1, k2);
      check_eq("rate2_k2", k2, k + 21);
      p0 = k2 + 1 + 128;
      nq.push_back(p0);
      run_to(p0 + 5);
      drain("rate2");

      // Control write exactly on the terminal-count edge wins.
      run_to(p0 + 126);
      wr_byte(8'hE0, 1'b1, k);
      w = k + 1;
      check_eq("tc_write_cycle", w, p0 + 128);
      nq.push_back(w + 32);
      run_to(w + 40);
      drain("tc_collide");

      // clk_en on alternate cycles at rate 1: 64 ticks = 128 cycles.
      en_alt = 1'b1;
      wr_byte(8'hE1, 1'b1, k);
      w = k + 1;
      f = ((w % 2) == 0) ? w + 2 : w + 1;
      nq.push_back(f + 126);
      nq.push_back(f + 126 + 128);
      run_to(f + 126 + 133);
      drain("clk_en_gate");
      en_alt = 1'b0;

      // Reset mid-count at rate 1; count restarts at rate 0.
      wr_byte(8'hE1, 1'b1, k);
      step(30);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      step(2);
      rst = 1'b0;
      r = cyc;
      nq.push_back(r + 32);
      run_to(r + 40);
      drain("midrst");
      check_eq("midrst_mode", int'(mode), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
